// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch sequencer.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ibuf_entry_t;
endpackage

// File: rtl/fetch_ibuf.sv
// Registered instruction FIFO: push visible at the head the cycle after, flush beats push/pop.
module fetch_ibuf
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ibuf_entry_t            push_dat,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output ibuf_entry_t            head
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  ibuf_entry_t   mem_q [DEPTH];
  ibuf_entry_t   mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // The fetch credit scheme reserves a slot per outstanding read, so a full push is a design bug.
  push_when_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/fetch_ctrl.sv
// RV32I fetch sequencer: owns the PC, issues credit-limited reads, squashes stale responses on redirect.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          IBUF_DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        o_mem_rvalid,
  output logic [31:0] o_mem_raddr,
  input  logic        i_mem_rready,
  input  logic        i_mem_rdata_valid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_inst_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  input  logic        i_inst_ready,
  output logic        o_fault
);
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW = $clog2(IBUF_DEPTH) + 1;
  localparam int SW = ((OW > BW) ? OW : BW) + 1;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
  logic [OW-1:0]   out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [BW-1:0]   buf_cnt;
  logic [SW-1:0]   credit_used;
  logic            buf_empty, buf_full;
  logic            accept, push, pop;
  ibuf_entry_t     head, push_dat;

  // Outstanding reads (including ones to be dropped) plus buffered words must fit the buffer.
  assign credit_used  = SW'(out_cnt_q) + SW'(buf_cnt);
  assign o_mem_rvalid = (state_q == ST_FETCH) && !redirect_valid
                        && (out_cnt_q < OW'(MAX_OUTSTANDING))
                        && (credit_used < SW'(IBUF_DEPTH));
  assign o_mem_raddr  = pc_q;
  assign accept       = o_mem_rvalid && i_mem_rready;
  assign push         = i_mem_rdata_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign pop          = o_inst_valid && i_inst_ready && !redirect_valid;
  assign push_dat     = '{pc: resp_pc_q, inst: i_mem_rdata};

  assign o_inst_valid = !buf_empty;
  assign o_inst       = head.inst;
  assign o_inst_pc    = head.pc;
  assign o_fault      = (state_q == ST_FAULT);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + OW'(accept) - OW'(i_mem_rdata_valid);
    if (state_q == ST_IDLE) state_d = ST_FETCH;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      resp_pc_d  = redirect_pc;
      // A response landing in the redirect cycle is discarded by the flush, not by drop_cnt.
      drop_cnt_d = out_cnt_q - OW'(i_mem_rdata_valid);
      state_d    = (redirect_pc[1:0] != 2'b00) ? ST_FAULT : ST_FETCH;
    end else begin
      if (accept) pc_d = pc_q + PC_INC;
      if (push) resp_pc_d = resp_pc_q + PC_INC;
      if (i_mem_rdata_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_ADDR;
      resp_pc_q  <= RESET_ADDR;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fetch_ibuf #(.DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (buf_cnt),
    .empty    (buf_empty),
    .full     (buf_full),
    .head     (head)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl with an in-order, 1-cycle-latency memory model.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        o_mem_rvalid;
  logic [31:0] o_mem_raddr;
  logic        i_mem_rready = 1'b0;
  logic        i_mem_rdata_valid = 1'b0;
  logic [31:0] i_mem_rdata = '0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;
  logic        o_fault;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  exp_t        got;
  logic [31:0] mem_pend[$];
  logic [31:0] exp_pc = '0;
  logic        mem_hold = 1'b0;
  int          accept_cnt = 0;
  int          pop_cnt = 0;

  fetch_ctrl #(.RESET_ADDR(32'h0), .MAX_OUTSTANDING(2), .IBUF_DEPTH(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .o_mem_rvalid      (o_mem_rvalid),
    .o_mem_raddr       (o_mem_raddr),
    .i_mem_rready      (i_mem_rready),
    .i_mem_rdata_valid (i_mem_rdata_valid),
    .i_mem_rdata       (i_mem_rdata),
    .o_inst_valid      (o_inst_valid),
    .o_inst            (o_inst),
    .o_inst_pc         (o_inst_pc),
    .i_inst_ready      (i_inst_ready),
    .o_fault           (o_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  // Memory: answers accepted reads in order, one cycle after acceptance.
  always @(posedge clk) begin
    #1;
    if (!rst && !mem_hold && mem_pend.size() > 0) begin
      i_mem_rdata_valid = 1'b1;
      i_mem_rdata       = mem_word(mem_pend.pop_front());
    end else begin
      i_mem_rdata_valid = 1'b0;
      i_mem_rdata       = $urandom;
    end
  end

  // Scoreboard: expected words queued at request acceptance, compared at decode pop.
  always @(negedge clk) begin
    if (!rst) begin
      if (redirect_valid) begin
        checks++;
        if (o_mem_rvalid !== 1'b0) begin
          failures++;
          $display("FAIL redirect_blocks_req: o_mem_rvalid=%b required 0", o_mem_rvalid);
        end
      end
      if (o_inst_valid && i_inst_ready && !redirect_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: pc=%h inst=%h required no instruction", o_inst_pc, o_inst);
        end else begin
          got = exp_q.pop_front();
          if (o_inst_pc !== got.pc || o_inst !== got.inst) begin
            failures++;
            $display("FAIL sb_inst: pc=%h inst=%h required pc=%h inst=%h", o_inst_pc, o_inst, got.pc, got.inst);
          end
        end
        pop_cnt++;
      end
      if (o_mem_rvalid && i_mem_rready) begin
        checks++;
        if (o_mem_raddr !== exp_pc) begin
          failures++;
          $display("FAIL req_addr: addr=%h required %h", o_mem_raddr, exp_pc);
        end
        exp_q.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
        mem_pend.push_back(o_mem_raddr);
        exp_pc = exp_pc + 32'd4;
        accept_cnt++;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_pc = redirect_pc;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    i_mem_rready = 1'b0;
    i_inst_ready = 1'b0;
    mem_hold = 1'b0;
    mem_pend.delete();
    exp_q.delete();
    exp_pc = 32'h0;
    accept_cnt = 0;
    pop_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_inst(input logic [31:0] want_pc, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (o_inst_valid) found = 1'b1;
    end
    checks++;
    if (!found || o_inst_pc !== want_pc || o_inst !== mem_word(want_pc)) begin
      failures++;
      $display("FAIL %s: valid=%b pc=%h inst=%h required pc=%h inst=%h",
               name, found, o_inst_pc, o_inst, want_pc, mem_word(want_pc));
    end
  endtask

  task automatic drain(input string name);
    i_mem_rready = 1'b0;
    i_inst_ready = 1'b1;
    mem_hold = 1'b0;
    repeat (5) step();
    checks++;
    if (o_inst_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: inst_valid=%b pending=%0d required 0 and 0", name, o_inst_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (o_mem_rvalid !== 1'b0 || o_inst_valid !== 1'b0 || o_fault !== 1'b0 ||
        o_mem_raddr !== 32'h0 || o_inst !== 32'h0 || o_inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: rvalid=%b ivalid=%b fault=%b raddr=%h inst=%h pc=%h required all 0",
               o_mem_rvalid, o_inst_valid, o_fault, o_mem_raddr, o_inst, o_inst_pc);
    end
  endtask

  task automatic test_stream();
    do_reset();
    i_mem_rready = 1'b1;
    i_inst_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (o_mem_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: rvalid=%b required 0", o_mem_rvalid);
    end
    step();
    @(negedge clk);
    checks++;
    if (o_mem_rvalid !== 1'b1 || o_mem_raddr !== 32'h0) begin
      failures++;
      $display("FAIL first_req: rvalid=%b addr=%h required 1 and 0", o_mem_rvalid, o_mem_raddr);
    end
    step();
    @(negedge clk);
    checks++;
    if (o_inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass: inst_valid=%b required 0", o_inst_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h0 || o_inst !== mem_word(32'h0)) begin
      failures++;
      $display("FAIL first_inst: valid=%b pc=%h required 1 and 0", o_inst_valid, o_inst_pc);
    end
    repeat (20) step();
    checks++;
    if (pop_cnt < 8) begin
      failures++;
      $display("FAIL stream_rate: pops=%0d required at least 8", pop_cnt);
    end
    drain("stream");
  endtask

  task automatic test_backpressure();
    do_reset();
    i_mem_rready = 1'b1;
    repeat (8) step();
    checks++;
    if (accept_cnt != 2 || o_mem_rvalid !== 1'b0 || o_inst_valid !== 1'b1 ||
        o_inst_pc !== 32'h0 || o_mem_raddr !== 32'h8) begin
      failures++;
      $display("FAIL backpressure: accepts=%0d rvalid=%b ivalid=%b pc=%h raddr=%h required 2 0 1 0 8",
               accept_cnt, o_mem_rvalid, o_inst_valid, o_inst_pc, o_mem_raddr);
    end
    i_inst_ready = 1'b1;
    repeat (12) step();
    checks++;
    if (pop_cnt < 6) begin
      failures++;
      $display("FAIL bp_resume: pops=%0d required at least 6", pop_cnt);
    end
    drain("backpressure");
  endtask

  task automatic test_mem_stall();
    do_reset();
    i_mem_rready = 1'b1;
    i_inst_ready = 1'b1;
    step();
    step();
    i_mem_rready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_mem_rvalid !== 1'b1 || o_mem_raddr !== 32'h4) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d rvalid=%b addr=%h required 1 and 4", i, o_mem_rvalid, o_mem_raddr);
      end
      step();
    end
    i_mem_rready = 1'b1;
    repeat (6) step();
    drain("mem_stall");
  endtask

  task automatic test_redirect_outstanding();
    do_reset();
    mem_hold = 1'b1;
    i_mem_rready = 1'b1;
    i_inst_ready = 1'b1;
    repeat (3) step();
    checks++;
    if (accept_cnt != 2 || o_mem_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL outstanding_cap: accepts=%0d rvalid=%b required 2 and 0", accept_cnt, o_mem_rvalid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    mem_hold = 1'b0;
    wait_inst(32'h100, "redirect_drop");
    drain("redirect_outstanding");
  endtask

  task automatic test_redirect_collision();
    do_reset();
    i_mem_rready = 1'b1;
    i_inst_ready = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    @(negedge clk);
    checks++;
    if (o_inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL collide_pop_present: inst_valid=%b required 1", o_inst_valid);
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_inst_valid !== 1'b0 || o_mem_rvalid !== 1'b1 || o_mem_raddr !== 32'h40) begin
      failures++;
      $display("FAIL collide_after: ivalid=%b rvalid=%b addr=%h required 0 1 40",
               o_inst_valid, o_mem_rvalid, o_mem_raddr);
    end
    wait_inst(32'h40, "collide_target");
    drain("redirect_collision");
  endtask

  task automatic test_fault();
    do_reset();
    i_mem_rready = 1'b1;
    i_inst_ready = 1'b1;
    repeat (4) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (o_fault !== 1'b1 || o_mem_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL fault_hold: cycle %0d fault=%b rvalid=%b required 1 and 0", i, o_fault, o_mem_rvalid);
      end
      step();
    end
    checks++;
    if (o_inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL fault_drained: inst_valid=%b required 0", o_inst_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_fault !== 1'b0 || o_mem_rvalid !== 1'b1 || o_mem_raddr !== 32'h200) begin
      failures++;
      $display("FAIL fault_clear: fault=%b rvalid=%b addr=%h required 0 1 200", o_fault, o_mem_rvalid, o_mem_raddr);
    end
    wait_inst(32'h200, "fault_recover");
    drain("fault");
  endtask

  task automatic test_wrap();
    int  acc0;
    logic seen = 1'b0;
    do_reset();
    i_mem_rready = 1'b1;
    i_inst_ready = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    acc0 = accept_cnt;
    for (int i = 0; i < 10 && accept_cnt < acc0 + 2; i++) step();
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (o_mem_rvalid) seen = 1'b1;
    end
    checks++;
    if (!seen || o_mem_raddr !== 32'h0) begin
      failures++;
      $display("FAIL pc_wrap: rvalid_seen=%b addr=%h required 1 and 0", seen, o_mem_raddr);
    end
    step();
    drain("wrap");
  endtask

  task automatic test_reset_midop();
    do_reset();
    i_mem_rready = 1'b1;
    i_inst_ready = 1'b1;
    repeat (6) step();
    rst = 1'b1;
    #1;
    checks++;
    if (o_mem_rvalid !== 1'b0 || o_inst_valid !== 1'b0 || o_fault !== 1'b0 ||
        o_mem_raddr !== 32'h0 || o_inst !== 32'h0 || o_inst_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_midop: rvalid=%b ivalid=%b fault=%b raddr=%h inst=%h pc=%h required all 0",
               o_mem_rvalid, o_inst_valid, o_fault, o_mem_raddr, o_inst, o_inst_pc);
    end
    do_reset();
    i_mem_rready = 1'b1;
    i_inst_ready = 1'b1;
    wait_inst(32'h0, "post_reset_fetch");
    drain("reset_midop");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_mem_stall();
    test_redirect_outstanding();
    test_redirect_collision();
    test_fault();
    test_wrap();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
